// File: rtl/pmp_seq_checker.sv
// Multi-cycle PMP access checker: scans one entry per cycle (lowest index wins) and returns
// allow/hit/index through a valid/ready response held until consumed.
module pmp_seq_checker #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned ADDR_W      = 32,
    localparam int unsigned IdxW       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [8*NUM_ENTRIES-1:0]          pmpcfg_i,
    input  logic [(ADDR_W-2)*NUM_ENTRIES-1:0] pmpaddr_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [ADDR_W-1:0]                 req_addr_i,
    input  logic [1:0]                        req_size_i,
    input  logic [1:0]                        req_type_i,
    input  logic                              req_priv_m_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic                              rsp_allow_o,
    output logic                              rsp_hit_o,
    output logic [IdxW-1:0]                   rsp_idx_o
);

    localparam int unsigned PaW = ADDR_W - 2;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        type_q, type_d;
    logic              priv_q, priv_d;
    logic              allow_q, allow_d;
    logic              hit_q, hit_d;
    logic [IdxW-1:0]   ridx_q, ridx_d;

    logic [7:0]     cfg_arr [NUM_ENTRIES];
    logic [PaW-1:0] pa_arr  [NUM_ENTRIES];

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            cfg_arr[i] = pmpcfg_i[i*8 +: 8];
            pa_arr[i]  = pmpaddr_i[i*PaW +: PaW];
        end
    end

    // Evaluation of the entry selected by idx_q against the captured request.
    logic [7:0]      cur_cfg;
    logic [PaW-1:0]  cur_pa, prev_pa, napot_mask;
    logic [ADDR_W:0] b0, b1, lo, top;
    logic            range_ok, full_hit, any_hit, perm_ok, entry_allow, overflow;

    always_comb begin
        cur_cfg    = cfg_arr[idx_q];
        cur_pa     = pa_arr[idx_q];
        prev_pa    = (idx_q == '0) ? '0 : pa_arr[idx_q - IdxW'(1)];
        // Trailing ones plus the next zero: the NAPOT offset bits of pmpaddr.
        napot_mask = cur_pa ^ (cur_pa + PaW'(1));
        b0         = {1'b0, addr_q};
        b1         = b0 + (ADDR_W + 1)'(size_q);
        overflow   = b1[ADDR_W];

        // Every mode is expressed as a half-open byte range [lo, top).
        unique case (cur_cfg[4:3])
            2'b01: begin
                lo  = {1'b0, prev_pa, 2'b00};
                top = {1'b0, cur_pa, 2'b00};
            end
            2'b10: begin
                lo  = {1'b0, cur_pa, 2'b00};
                top = {1'b0, cur_pa, 2'b00} + (ADDR_W + 1)'(4);
            end
            2'b11: begin
                lo  = {1'b0, cur_pa & ~napot_mask, 2'b00};
                top = {1'b0, cur_pa | napot_mask, 2'b11} + (ADDR_W + 1)'(1);
            end
            default: begin
                lo  = '0;
                top = '0;
            end
        endcase

        range_ok = lo < top;
        full_hit = range_ok && (lo <= b0) && (b1 < top);
        any_hit  = range_ok && (b0 < top) && (b1 >= lo);

        case (type_q)
            2'b00:   perm_ok = cur_cfg[0];
            2'b01:   perm_ok = cur_cfg[1];
            2'b10:   perm_ok = cur_cfg[2];
            default: perm_ok = 1'b0;
        endcase

        if (!full_hit) begin
            entry_allow = 1'b0;
        end else if (priv_q && !cur_cfg[7]) begin
            entry_allow = 1'b1;
        end else begin
            entry_allow = perm_ok;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        size_d  = size_q;
        type_d  = type_q;
        priv_d  = priv_q;
        allow_d = allow_q;
        hit_d   = hit_q;
        ridx_d  = ridx_q;

        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    type_d  = req_type_i;
                    priv_d  = req_priv_m_i;
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (overflow) begin
                    allow_d = 1'b0;
                    hit_d   = 1'b0;
                    ridx_d  = '0;
                    state_d = StResp;
                end else if (any_hit) begin
                    allow_d = entry_allow;
                    hit_d   = 1'b1;
                    ridx_d  = idx_q;
                    state_d = StResp;
                end else if (idx_q == LastIdx) begin
                    allow_d = priv_q;
                    hit_d   = 1'b0;
                    ridx_d  = '0;
                    state_d = StResp;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            type_q  <= '0;
            priv_q  <= 1'b0;
            allow_q <= 1'b0;
            hit_q   <= 1'b0;
            ridx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            type_q  <= type_d;
            priv_q  <= priv_d;
            allow_q <= allow_d;
            hit_q   <= hit_d;
            ridx_q  <= ridx_d;
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_allow_o = allow_q;
    assign rsp_hit_o   = hit_q;
    assign rsp_idx_o   = ridx_q;

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Directed bench for pmp_seq_checker with four entries: hand-computed allow/hit/idx/latency.
module tb_pmp_seq_checker;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [8*N-1:0]    pmpcfg;
    logic [30*N-1:0]   pmpaddr;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [AW-1:0]     req_addr = '0;
    logic [1:0]        req_size = '0;
    logic [1:0]        req_type = '0;
    logic              req_priv_m = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_allow;
    logic              rsp_hit;
    logic [1:0]        rsp_idx;

    logic [7:0]  cfg_a [N];
    logic [29:0] pa_a  [N];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            pmpcfg[i*8 +: 8]   = cfg_a[i];
            pmpaddr[i*30 +: 30] = pa_a[i];
        end
    end

    pmp_seq_checker #(
        .NUM_ENTRIES(N),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pmpcfg_i    (pmpcfg),
        .pmpaddr_i   (pmpaddr),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_size_i  (req_size),
        .req_type_i  (req_type),
        .req_priv_m_i(req_priv_m),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_allow_o (rsp_allow),
        .rsp_hit_o   (rsp_hit),
        .rsp_idx_o   (rsp_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_entries();
        for (int i = 0; i < N; i++) begin
            cfg_a[i] = 8'h00;
            pa_a[i]  = 30'h0;
        end
    endtask

    // Issue one request, measure edges from accept to rsp_valid, check result, consume it.
    task automatic do_req(input string tag, input logic [31:0] a, input logic [1:0] sz,
                          input logic [1:0] ty, input logic pm, input int exp_lat,
                          input logic exp_allow, input logic exp_hit, input logic [1:0] exp_idx);
        int lat;
        @(negedge clk);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_addr   = a;
        req_size   = sz;
        req_type   = ty;
        req_priv_m = pm;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".allow"}, 32'(rsp_allow), 32'(exp_allow));
        check({tag, ".hit"}, 32'(rsp_hit), 32'(exp_hit));
        check({tag, ".idx"}, 32'(rsp_idx), 32'(exp_idx));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, ".done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int lat;
        clear_entries();
        #12;
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.valid", 32'(rsp_valid), 32'd0);
        check("rst.allow", 32'(rsp_allow), 32'd0);
        check("rst.hit", 32'(rsp_hit), 32'd0);
        check("rst.idx", 32'(rsp_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // NA4 at byte 0x64, R+W.
        cfg_a[0] = 8'h13;
        pa_a[0]  = 30'h19;
        do_req("na4_full",   32'h64, 2'd0, 2'b00, 1'b0, 1, 1'b1, 1'b1, 2'd0);
        do_req("na4_part",   32'h67, 2'd1, 2'b00, 1'b0, 1, 1'b0, 1'b1, 2'd0);
        do_req("na4_wr_m",   32'h64, 2'd3, 2'b01, 1'b1, 1, 1'b1, 1'b1, 2'd0);
        do_req("na4_x_u",    32'h64, 2'd0, 2'b10, 1'b0, 1, 1'b0, 1'b1, 2'd0);
        do_req("na4_t11_u",  32'h64, 2'd0, 2'b11, 1'b0, 1, 1'b0, 1'b1, 2'd0);

        // All entries off.
        clear_entries();
        do_req("ovf",        32'hFFFF_FFFF, 2'd2, 2'b00, 1'b1, 1, 1'b0, 1'b0, 2'd0);
        do_req("nohit_m",    32'h1000, 2'd0, 2'b00, 1'b1, 4, 1'b1, 1'b0, 2'd0);
        do_req("nohit_u",    32'h1000, 2'd0, 2'b00, 1'b0, 4, 1'b0, 1'b0, 2'd0);
        do_req("top_byte_m", 32'hFFFF_FFFF, 2'd0, 2'b00, 1'b1, 4, 1'b1, 1'b0, 2'd0);

        // Entry 3 NAPOT 8 KiB at 0, X only.
        cfg_a[3] = 8'h1C;
        pa_a[3]  = 30'h3FF;
        do_req("napot_wr_u", 32'h100, 2'd3, 2'b01, 1'b0, 4, 1'b0, 1'b1, 2'd3);
        do_req("napot_x_u",  32'h100, 2'd0, 2'b10, 1'b0, 4, 1'b1, 1'b1, 2'd3);
        do_req("napot_edge", 32'h1FFE, 2'd3, 2'b00, 1'b1, 4, 1'b0, 1'b1, 2'd3);
        do_req("napot_out",  32'h2000, 2'd0, 2'b00, 1'b1, 4, 1'b1, 1'b0, 2'd0);

        // TOR entry 1 over 0x400..0x7FF, locked, R only.
        clear_entries();
        pa_a[0]  = 30'h100;
        pa_a[1]  = 30'h200;
        cfg_a[1] = 8'h89;
        do_req("tor_wr_m",   32'h7FC, 2'd0, 2'b01, 1'b1, 2, 1'b0, 1'b1, 2'd1);
        do_req("tor_rd_u",   32'h7FC, 2'd0, 2'b00, 1'b0, 2, 1'b1, 1'b1, 2'd1);
        do_req("tor_lo",     32'h400, 2'd3, 2'b00, 1'b0, 2, 1'b1, 1'b1, 2'd1);
        do_req("tor_below",  32'h3FC, 2'd3, 2'b00, 1'b0, 4, 1'b0, 1'b0, 2'd0);
        do_req("tor_part",   32'h7FE, 2'd3, 2'b00, 1'b1, 2, 1'b0, 1'b1, 2'd1);
        do_req("tor_above",  32'h800, 2'd0, 2'b00, 1'b0, 4, 1'b0, 1'b0, 2'd0);

        // Entry 2 NAPOT all-ones covers everything, R only.
        cfg_a[2] = 8'h19;
        pa_a[2]  = 30'h3FFF_FFFF;
        do_req("all_rd_u",   32'hFFFF_FFFC, 2'd3, 2'b00, 1'b0, 3, 1'b1, 1'b1, 2'd2);
        do_req("all_wr_u",   32'h10, 2'd0, 2'b01, 1'b0, 3, 1'b0, 1'b1, 2'd2);
        do_req("all_prio",   32'h7FC, 2'd0, 2'b00, 1'b0, 2, 1'b1, 1'b1, 2'd1);

        // Hold the response, then reset while it is pending.
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = 32'h7FC;
        req_size   = 2'd0;
        req_type   = 2'b00;
        req_priv_m = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("hold.lat", 32'(lat), 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold.valid", 32'(rsp_valid), 32'd1);
            check("hold.allow", 32'(rsp_allow), 32'd1);
            check("hold.hit", 32'(rsp_hit), 32'd1);
            check("hold.idx", 32'(rsp_idx), 32'd1);
            check("hold.ready", 32'(req_ready), 32'd0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("areset.ready", 32'(req_ready), 32'd1);
        check("areset.valid", 32'(rsp_valid), 32'd0);
        check("areset.allow", 32'(rsp_allow), 32'd0);
        check("areset.hit", 32'(rsp_hit), 32'd0);
        check("areset.idx", 32'(rsp_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req("post_rst",   32'h7FC, 2'd0, 2'b00, 1'b0, 2, 1'b1, 1'b1, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
